// File: rtl/binary_to_decimal_decoder.sv
// rtl/binary_to_decimal_decoder.sv - buffered 4-bit code to one-hot decimal digit decoder
//
// Codes enter through a valid/ready handshake into a small FIFO. The head of
// the FIFO is decoded into a registered one-hot digit, which is held under
// output backpressure. Illegal codes (10-15) produce an all-zero one-hot
// value with out_err set, and are counted at acceptance in a saturating
// counter.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - in_code holds a code to accept
//   in_ready   - a code can be accepted this cycle
//   in_code    - binary digit code, 0-9 legal, 10-15 illegal
//   out_valid  - out_onehot/out_err hold a decoded result
//   out_ready  - consumer takes the result this cycle
//   out_onehot - one-hot decimal digit, bit n for code n
//   out_err    - presented result came from an illegal code
//   clr_err    - synchronous clear of err_count (wins over increment)
//   err_count  - saturating count of accepted illegal codes

module binary_to_decimal_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] out_onehot,
  output logic       out_err,
  input  logic       clr_err,
  output logic [7:0] err_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [3:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] occupancy;
  logic          ready_en;
  logic          push;
  logic          pop;
  logic [3:0]    head_code;

  function automatic logic [9:0] onehot_of(input logic [3:0] code);
    onehot_of = (code <= 4'd9) ? (10'd1 << code) : 10'd0;
  endfunction

  // ready_en keeps in_ready low during reset and until the first edge after
  // release, so nothing is accepted before the block is out of reset.
  assign in_ready  = ready_en && (occupancy < DEPTH_C);
  assign push      = in_valid && in_ready;
  assign pop       = (occupancy != '0) && (!out_valid || out_ready);
  assign head_code = mem[rd_ptr];

  // Storage needs no reset: occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      ready_en <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Output stage: data regs are zeroed whenever out_valid drops so that an
  // idle output always reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_onehot <= 10'd0;
      out_err    <= 1'b0;
    end else if (pop) begin
      out_valid  <= 1'b1;
      out_onehot <= onehot_of(head_code);
      out_err    <= (head_code > 4'd9);
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
      out_onehot <= 10'd0;
      out_err    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (clr_err) begin
      err_count <= 8'd0;
    end else if (push && (in_code > 4'd9) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_binary_to_decimal_decoder.sv
// tb/tb_binary_to_decimal_decoder.sv - directed self-checking bench for binary_to_decimal_decoder

module tb_binary_to_decimal_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_onehot;
  logic       out_err;
  logic       clr_err;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  binary_to_decimal_decoder #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_err    (out_err),
    .clr_err    (clr_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [9:0] oh, input logic e);
    check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, "_onehot"}, {22'd0, out_onehot}, {22'd0, oh});
    check({tag, "_err"}, {31'd0, out_err}, {31'd0, e});
  endtask

  logic [9:0] exp_oh;
  logic [3:0] codes_a [6];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = 4'd0;
    out_ready = 1'b0;
    clr_err   = 1'b0;

    // Reset state
    tick();
    tick();
    check_out("reset", 1'b0, 10'd0, 1'b0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_err_count", {24'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", {31'd0, in_ready}, 32'd0);
    tick();
    check("ready_after_edge", {31'd0, in_ready}, 32'd1);

    // Single digit 7, two-edge latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_code   = 4'd7;
    tick();
    in_valid = 1'b0;
    check_out("single_k", 1'b0, 10'd0, 1'b0);
    tick();
    check_out("single_k1", 1'b1, 10'b0010000000, 1'b0);
    tick();
    check_out("single_drain", 1'b0, 10'd0, 1'b0);

    // Sweep 0..15 back-to-back: result i appears after edge i+1
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_code  = 4'(i);
      check("sweep_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      if (i >= 1) begin
        exp_oh = (i - 1 < 10) ? (10'd1 << (i - 1)) : 10'd0;
        check_out($sformatf("sweep_%0d", i - 1), 1'b1, exp_oh, (i - 1 >= 10));
      end
    end
    in_valid = 1'b0;
    tick();
    check_out("sweep_15", 1'b1, 10'd0, 1'b1);
    check("sweep_err_count", {24'd0, err_count}, 32'd6);
    tick();
    check_out("sweep_drain", 1'b0, 10'd0, 1'b0);

    // Backpressure and full FIFO
    out_ready = 1'b0;
    codes_a[0] = 4'd3; codes_a[1] = 4'd1; codes_a[2] = 4'd4;
    codes_a[3] = 4'd1; codes_a[4] = 4'd5; codes_a[5] = 4'd9;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_code  = codes_a[i];
      check("bp_accept_ready", {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_code = codes_a[5];
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    check_out("bp_hold3", 1'b1, 10'b0000001000, 1'b0);
    check("bp_still_full", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    check_out("bp_out1a", 1'b1, 10'b0000000010, 1'b0);
    check("bp_room", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_out("bp_out4", 1'b1, 10'b0000010000, 1'b0);
    tick();
    check_out("bp_out1b", 1'b1, 10'b0000000010, 1'b0);
    tick();
    check_out("bp_out5", 1'b1, 10'b0000100000, 1'b0);
    tick();
    check_out("bp_out9", 1'b1, 10'b1000000000, 1'b0);
    tick();
    check_out("bp_drain", 1'b0, 10'd0, 1'b0);

    // Pop pulse while full with in_valid held
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_code  = 4'(2 + i);
      tick();
    end
    in_code = 4'd8;
    check("pp_full", {31'd0, in_ready}, 32'd0);
    check_out("pp_head", 1'b1, 10'b0000000100, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_out("pp_pop3", 1'b1, 10'b0000001000, 1'b0);
    check("pp_room", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("pp_refull", {31'd0, in_ready}, 32'd0);
    check_out("pp_hold3", 1'b1, 10'b0000001000, 1'b0);
    out_ready = 1'b1;
    tick();
    check_out("pp_out4", 1'b1, 10'b0000010000, 1'b0);
    check("pp_ready_again", {31'd0, in_ready}, 32'd1);
    tick();
    check_out("pp_out5", 1'b1, 10'b0000100000, 1'b0);
    tick();
    check_out("pp_out6", 1'b1, 10'b0001000000, 1'b0);
    tick();
    check_out("pp_out8", 1'b1, 10'b0100000000, 1'b0);
    tick();
    check_out("pp_drain", 1'b0, 10'd0, 1'b0);

    // Error counter saturation and clear priority (starts at 6)
    in_valid = 1'b1;
    in_code  = 4'd12;
    for (int i = 0; i < 100; i++) tick();
    check("err_106", {24'd0, err_count}, 32'd106);
    check_out("err_result", 1'b1, 10'd0, 1'b1);
    for (int i = 0; i < 160; i++) tick();
    check("err_sat", {24'd0, err_count}, 32'd255);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("err_clr_prio", {24'd0, err_count}, 32'd0);
    tick();
    check("err_after_clr", {24'd0, err_count}, 32'd1);
    in_valid = 1'b0;
    tick();
    tick();
    check_out("err_drain", 1'b0, 10'd0, 1'b0);

    // Reset mid-stream: out holds 1, FIFO holds 2,11,4
    out_ready = 1'b0;
    codes_a[0] = 4'd1; codes_a[1] = 4'd2; codes_a[2] = 4'd11; codes_a[3] = 4'd4;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_code  = codes_a[i];
      tick();
    end
    in_valid = 1'b0;
    check("rst_pre_count", {24'd0, err_count}, 32'd2);
    check_out("rst_pre", 1'b1, 10'b0000000010, 1'b0);
    rst_n = 1'b0;
    #1;
    check_out("rst_async", 1'b0, 10'd0, 1'b0);
    check("rst_async_ready", {31'd0, in_ready}, 32'd0);
    check("rst_async_err_count", {24'd0, err_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    check_out("rst_no_stale", 1'b0, 10'd0, 1'b0);
    in_valid = 1'b1;
    in_code  = 4'd2;
    tick();
    in_valid = 1'b0;
    tick();
    check_out("rst_push2", 1'b1, 10'b0000000100, 1'b0);
    tick();
    check_out("rst_final_drain", 1'b0, 10'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/binary_to_decimal_decoder.md
BINARY_TO_DECIMAL_DECODER -- requirements
Module: binary_to_decimal_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, input buffer depth in entries; legal values are powers of two, 2 to 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: in_code holds a code to be accepted.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a code this cycle.
REQ-006 SHALL have port in_code, input, 4 bits: binary digit code; 0-9 legal, 10-15 illegal.
REQ-007 SHALL have port out_valid, output, 1 bit: out_onehot/out_err hold a decoded result.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer takes the result this cycle.
REQ-009 SHALL have port out_onehot, output, 10 bits: one-hot decimal digit, bit n set for code n.
REQ-010 SHALL have port out_err, output, 1 bit: the presented result came from an illegal code.
REQ-011 SHALL have port clr_err, input, 1 bit: synchronous clear of err_count.
REQ-012 SHALL have port err_count, output, 8 bits: saturating count of illegal codes accepted.

Function
REQ-013 SHALL accept a code on a rising edge where in_valid=1 and in_ready=1 (input handshake) and write it into the FIFO.
REQ-014 SHALL drive in_ready = 1 exactly when FIFO occupancy < FIFO_DEPTH (combinational from occupancy only, not from out_ready).
REQ-015 SHALL ignore in_code when in_valid=0 or in_ready=0; no state change.
REQ-016 SHALL keep occupancy 0..FIFO_DEPTH: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-017 SHALL use wrap-around read/write pointers of log2(FIFO_DEPTH) bits; entries leave in acceptance order.
REQ-018 SHALL load the output register from the FIFO head (pop) on a rising edge where the FIFO is non-empty and (out_valid=0 or out_ready=1).
REQ-019 SHALL set out_valid=1 on a load; SHALL clear out_valid on a rising edge where out_valid=1, out_ready=1 and no load occurs.
REQ-020 SHALL hold out_onehot, out_err and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL decode a legal code n as out_onehot = 1 << n, out_err = 0.
REQ-022 SHALL decode an illegal code (10-15) as out_onehot = 10'b0, out_err = 1.
REQ-023 SHALL give latency of exactly 2 rising edges from acceptance to out_valid=1 when FIFO and output stage are empty: push at edge k, load at edge k+1.
REQ-024 SHALL sustain 1 result per cycle when in_valid and out_ready are held at 1.
REQ-025 SHALL increment err_count on each accepted illegal code, counted at input acceptance; it saturates at 255.
REQ-026 SHALL give clr_err priority over increment: on an edge where clr_err=1, err_count becomes 0 even if an illegal code is accepted.
REQ-027 SHALL drive out_onehot = 10'b0 and out_err = 0 whenever out_valid=0.

Reset
REQ-028 SHALL, while rst_n=0, immediately force: occupancy 0, pointers 0, out_valid 0, out_onehot 0, out_err 0, err_count 0, in_ready 0.
REQ-029 SHALL discard all buffered and presented data on reset mid-operation; no partial result is presented after release.
REQ-030 SHALL raise in_ready on the first rising edge after rst_n deasserts; no code is accepted before that edge.

Verification
REQ-031 Single digit: push code 7, out_ready=1 -> out_valid high 2 edges after acceptance, out_onehot=10'b0010000000, out_err=0.
REQ-032 Sweep: stream codes 0..15 back-to-back, out_ready=1 -> 16 results in order; codes 0-9 one-hot 1<<n, codes 10-15 onehot 0 and err 1; err_count=6; one result per cycle.
REQ-033 Backpressure/full: out_ready=0, push 3,1,4,1,5,9 with FIFO_DEPTH=4 -> 5 accepted (4 in FIFO, 1 in output register), then in_ready=0 and 9 stalls; raise out_ready -> output order 3,1,4,1,5,9, and out_onehot holds 3 throughout the stall.
REQ-034 Simultaneous push/pop at full: FIFO full and out_valid=1; pulse out_ready one cycle while in_valid=1 -> occupancy stays at the correct value, no loss or duplication.
REQ-035 Error counter: accept 260 illegal codes -> err_count=255; on the same edge as an illegal accept, clr_err=1 -> err_count=0.
REQ-036 Reset mid-stream: assert rst_n=0 with 3 entries buffered and out_valid=1 -> all outputs zero asynchronously; after release, no stale data appears and the next push of code 2 yields 10'b0000000100.
